// File: rtl/ram_ahb_bist_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_ahb_bist_master                                                        |
// | AHB-Lite initiator that writes a seeded pattern over an SRAM region, reads |
// | it back and reports pass/fail, a mismatch count and the first bad address. |
// | Optional macro RAM_BIST_INV_PASS_EN adds a second pass with ~pattern.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ram_ahb_bist_master #(
  parameter int AW   = 13,
  parameter int ERRW = 16
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            start,
  input  logic [31:0]     base_addr,
  input  logic [AW-2:0]   num_words,
  input  logic [31:0]     seed,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            bus_err,
  output logic [ERRW-1:0] err_count,
  output logic [31:0]     first_err_addr,
  output logic [31:0]     HADDR,
  output logic [1:0]      HTRANS,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [31:0]     HWDATA,
  input  logic [31:0]     HRDATA,
  input  logic            HREADY,
  input  logic            HRESP
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [1:0]      TR_IDLE   = 2'b00;
  localparam logic [1:0]      TR_NONSEQ = 2'b10;
  localparam logic [AW-2:0]   IDX_ONE   = {{(AW-2){1'b0}}, 1'b1};
  localparam logic [ERRW-1:0] ERR_ONE   = {{(ERRW-1){1'b0}}, 1'b1};

  logic [2:0]      state_q, state_d;
  logic [31:0]     haddr_q, haddr_d;
  logic [1:0]      htrans_q, htrans_d;
  logic            hwrite_q, hwrite_d;
  logic [31:0]     hwdata_q, hwdata_d;
  logic [AW-2:0]   idx_q, idx_d;
  logic [AW-2:0]   num_q, num_d;
  logic [31:0]     base_q, base_d;
  logic [31:0]     seed_q, seed_d;
  logic            inv_q, inv_d;
  logic            dval_q, dval_d;
  logic            dwr_q, dwr_d;
  logic            dinv_q, dinv_d;
  logic [AW-3:0]   didx_q, didx_d;
  logic [31:0]     daddr_q, daddr_d;
  logic            bus_err_q, bus_err_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]     first_err_q, first_err_d;
  logic            result_q, result_d;

  logic            accept;
  logic            last_idx;
  logic            unused_base_lsb;

  function automatic logic [31:0] pat(input logic [31:0] s, input logic [AW-3:0] i,
                                      input logic inv);
    logic [31:0] p;
    p = s ^ {{(34-AW){1'b0}}, i};
    return inv ? ~p : p;
  endfunction

  assign unused_base_lsb = &{1'b0, base_addr[1:0]};
  assign accept          = (htrans_q == TR_NONSEQ) && HREADY;
  assign last_idx        = (idx_q + IDX_ONE) == num_q;

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    idx_d       = idx_q;
    num_d       = num_q;
    base_d      = base_q;
    seed_d      = seed_q;
    inv_d       = inv_q;
    dval_d      = dval_q;
    dwr_d       = dwr_q;
    dinv_d      = dinv_q;
    didx_d      = didx_q;
    daddr_d     = daddr_q;
    bus_err_d   = bus_err_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    result_d    = result_q;

    // A completed data phase retires the pipeline slot unless a new one is accepted.
    if (HREADY) begin
      dval_d   = 1'b0;
      hwdata_d = '0;
    end

    if (dval_q && HREADY && !HRESP && !dwr_q &&
        (HRDATA != pat(seed_q, didx_q, dinv_q))) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_ONE;
      if (err_cnt_q == '0) first_err_d = daddr_q;
    end

    if (accept) begin
      dval_d  = 1'b1;
      dwr_d   = hwrite_q;
      dinv_d  = inv_q;
      didx_d  = idx_q[AW-3:0];
      daddr_d = haddr_q;
      if (hwrite_q) hwdata_d = pat(seed_q, idx_q[AW-3:0], inv_q);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bus_err_d   = 1'b0;
          err_cnt_d   = '0;
          first_err_d = '0;
          result_d    = 1'b0;
          base_d      = {base_addr[31:2], 2'b00};
          num_d       = num_words;
          seed_d      = seed;
          inv_d       = 1'b0;
          idx_d       = '0;
          if (num_words == '0) begin
            state_d = S_FIN;
          end else begin
            state_d  = S_WR;
            htrans_d = TR_NONSEQ;
            hwrite_d = 1'b1;
            haddr_d  = {base_addr[31:2], 2'b00};
          end
        end
      end
      S_WR: begin
        if (accept) begin
          if (last_idx) begin
            state_d  = S_RD;
            idx_d    = '0;
            haddr_d  = base_q;
            hwrite_d = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            haddr_d = haddr_q + 32'd4;
          end
        end
      end
      S_RD: begin
        if (accept) begin
          if (last_idx) begin
`ifdef RAM_BIST_INV_PASS_EN
            if (!inv_q) begin
              state_d  = S_WR;
              inv_d    = 1'b1;
              idx_d    = '0;
              haddr_d  = base_q;
              hwrite_d = 1'b1;
            end else begin
              state_d  = S_DRAIN;
              htrans_d = TR_IDLE;
            end
`else
            state_d  = S_DRAIN;
            htrans_d = TR_IDLE;
`endif
          end else begin
            idx_d   = idx_q + IDX_ONE;
            haddr_d = haddr_q + 32'd4;
          end
        end
      end
      S_DRAIN: begin
        if (HREADY) state_d = S_FIN;
      end
      S_FIN: begin
        state_d  = S_IDLE;
        result_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // First ERROR cycle: withdraw the pending address phase and wind down.
    if (dval_q && HRESP && !HREADY) begin
      bus_err_d = 1'b1;
      htrans_d  = TR_IDLE;
      hwrite_d  = 1'b0;
      if (state_q == S_WR || state_q == S_RD) state_d = S_DRAIN;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      haddr_q     <= '0;
      htrans_q    <= TR_IDLE;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      idx_q       <= '0;
      num_q       <= '0;
      base_q      <= '0;
      seed_q      <= '0;
      inv_q       <= 1'b0;
      dval_q      <= 1'b0;
      dwr_q       <= 1'b0;
      dinv_q      <= 1'b0;
      didx_q      <= '0;
      daddr_q     <= '0;
      bus_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      result_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      base_q      <= base_d;
      seed_q      <= seed_d;
      inv_q       <= inv_d;
      dval_q      <= dval_d;
      dwr_q       <= dwr_d;
      dinv_q      <= dinv_d;
      didx_q      <= didx_d;
      daddr_q     <= daddr_d;
      bus_err_q   <= bus_err_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      result_q    <= result_d;
    end
  end

  assign busy           = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done           = (state_q == S_FIN);
  assign pass           = ((state_q == S_FIN) || result_q) && (err_cnt_q == '0) && !bus_err_q;
  assign bus_err        = bus_err_q;
  assign err_count      = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign HADDR          = haddr_q;
  assign HTRANS         = htrans_q;
  assign HWRITE         = hwrite_q;
  assign HWDATA         = hwdata_q;
  assign HSIZE          = 3'b010;
  assign HBURST         = 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_ram_ahb_bist_master.sv
`default_nettype none
// Directed bench for ram_ahb_bist_master with a behavioural AHB SRAM slave
// supporting wait states, a stuck-at bit and an injected ERROR response.
module tb_ram_ahb_bist_master;
  localparam int AW   = 13;
  localparam int ERRW = 16;
`ifdef RAM_BIST_INV_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic            HCLK = 1'b0;
  logic            HRESETn = 1'b0;
  logic            start = 1'b0;
  logic [31:0]     base_addr = '0;
  logic [AW-2:0]   num_words = '0;
  logic [31:0]     seed = '0;
  logic            busy, done, pass, bus_err;
  logic [ERRW-1:0] err_count;
  logic [31:0]     first_err_addr, HADDR, HWDATA;
  logic [1:0]      HTRANS;
  logic            HWRITE;
  logic [2:0]      HSIZE, HBURST;
  logic [31:0]     HRDATA = '0;
  logic            HREADY = 1'b1;
  logic            HRESP = 1'b0;

  int checks = 0;
  int errors = 0;

  ram_ahb_bist_master #(.AW(AW), .ERRW(ERRW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .bus_err(bus_err), .err_count(err_count), .first_err_addr(first_err_addr),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Slave model state
  logic [31:0] mem [0:63];
  bit          dph_v, dph_w, err_pending, err_seen, prev_stall;
  logic [31:0] dph_a, s_addr, s_wdata, wdat;
  logic [1:0]  s_trans;
  logic        s_write;
  int          waits, waits_left, stall_viol, ns_after_err;
  bit          stuck_en, err_en;
  logic [5:0]  stuck_word;
  logic [31:0] err_addr;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      dph_v = 0; err_pending = 0; prev_stall = 0;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    end else begin
      if (prev_stall && (HADDR !== s_addr || HTRANS !== s_trans ||
                         HWRITE !== s_write || HWDATA !== s_wdata)) stall_viol++;
      if (err_seen && HTRANS === 2'b10) ns_after_err++;
      HREADY = 1'b1; HRESP = 1'b0;
      if (err_pending) begin
        HRESP = 1'b1; err_pending = 0; dph_v = 0;
      end else if (dph_v && dph_w && err_en && dph_a == err_addr) begin
        HREADY = 1'b0; HRESP = 1'b1; err_pending = 1; err_seen = 1;
      end else if (dph_v && waits_left > 0) begin
        HREADY = 1'b0; waits_left--;
      end else if (dph_v) begin
        if (dph_w) begin
          wdat = HWDATA;
          if (stuck_en && dph_a[7:2] == stuck_word) wdat[5] = 1'b0;
          mem[dph_a[7:2]] = wdat;
        end else begin
          HRDATA = mem[dph_a[7:2]];
        end
        dph_v = 0;
      end
      if (HREADY && HTRANS === 2'b10) begin
        dph_v = 1; dph_a = HADDR; dph_w = HWRITE; waits_left = waits;
      end
      prev_stall = !HREADY && !HRESP;
      s_addr = HADDR; s_trans = HTRANS; s_write = HWRITE; s_wdata = HWDATA;
    end
  end

  function automatic logic [31:0] pat_f(input logic [31:0] s, input int i);
    logic [31:0] p;
    p = s ^ i;
    return (PASSES == 2) ? ~p : p;
  endfunction

  task automatic step();
    @(negedge HCLK);
    #1;
  endtask

  task automatic prep(input int w, input bit se, input logic [5:0] sw,
                      input bit ee, input logic [31:0] ea);
    waits = w; stuck_en = se; stuck_word = sw; err_en = ee; err_addr = ea;
    err_seen = 0; stall_viol = 0; ns_after_err = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD0000 | i;
  endtask

  task automatic do_start(input logic [31:0] b, input int n, input logic [31:0] s);
    base_addr = b; num_words = n[AW-2:0]; seed = s; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc, output bit ok);
    cyc = c0; ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (done === 1'b1) begin ok = 1; break; end
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    step(); step();
    checks++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin
      errors++; $display("FAIL reset_bus got trans=%b addr=%h wr=%b wdata=%h want 0", HTRANS, HADDR, HWRITE, HWDATA); end
    checks++; if (busy !== 0 || done !== 0 || pass !== 0 || bus_err !== 0) begin
      errors++; $display("FAIL reset_status got busy=%b done=%b pass=%b berr=%b want 0", busy, done, pass, bus_err); end
    checks++; if (err_count !== '0 || first_err_addr !== 32'h0 || HSIZE !== 3'b010 || HBURST !== 3'b000) begin
      errors++; $display("FAIL reset_regs got cnt=%h fea=%h hsize=%b hburst=%b", err_count, first_err_addr, HSIZE, HBURST); end
    HRESETn = 1'b1;
    step();
  endtask

  task automatic test_zero_wait();
    int cyc; bit ok;
    prep(0, 0, 0, 0, 0);
    do_start(32'h0, 4, 32'hA5A50000);
    checks++; if (busy !== 1'b1 || HTRANS !== 2'b10 || HWRITE !== 1'b1 || HADDR !== 32'h0) begin
      errors++; $display("FAIL zw_first_addr got busy=%b trans=%b wr=%b addr=%h want 1/10/1/0", busy, HTRANS, HWRITE, HADDR); end
    wait_done(1, cyc, ok);
    checks++; if (!ok || cyc != PASSES*8+2) begin
      errors++; $display("FAIL zw_done_cycle got %0d (seen=%0d) want %0d", cyc, ok, PASSES*8+2); end
    checks++; if (pass !== 1'b1 || err_count !== '0 || bus_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zw_result got pass=%b cnt=%0d berr=%b busy=%b want 1/0/0/0", pass, err_count, bus_err, busy); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[i] !== pat_f(32'hA5A50000, i)) begin
        errors++; $display("FAIL zw_mem%0d got %h want %h", i, mem[i], pat_f(32'hA5A50000, i)); end
    end
    step();
    checks++; if (done !== 1'b0 || pass !== 1'b1) begin
      errors++; $display("FAIL zw_done_pulse got done=%b pass=%b want 0/1", done, pass); end
  endtask

  task automatic test_wait_states();
    int cyc; bit ok;
    prep(2, 0, 0, 0, 0);
    do_start(32'h0, 4, 32'hA5A50000);
    wait_done(1, cyc, ok);
    checks++; if (!ok || cyc != PASSES*24+2) begin
      errors++; $display("FAIL ws_done_cycle got %0d (seen=%0d) want %0d", cyc, ok, PASSES*24+2); end
    checks++; if (stall_viol != 0) begin
      errors++; $display("FAIL ws_stable got %0d changes during stall want 0", stall_viol); end
    checks++; if (pass !== 1'b1 || err_count !== '0) begin
      errors++; $display("FAIL ws_result got pass=%b cnt=%0d want 1/0", pass, err_count); end
    checks++; if (mem[3] !== pat_f(32'hA5A50000, 3)) begin
      errors++; $display("FAIL ws_mem3 got %h want %h", mem[3], pat_f(32'hA5A50000, 3)); end
    step();
  endtask

  task automatic test_stuck_bit();
    int cyc; bit ok;
    prep(0, 1, 6'd2, 0, 0);
    do_start(32'h100, 4, 32'h20);
    wait_done(1, cyc, ok);
    checks++; if (!ok || cyc != PASSES*8+2) begin
      errors++; $display("FAIL sb_done_cycle got %0d (seen=%0d) want %0d", cyc, ok, PASSES*8+2); end
    checks++; if (err_count !== 16'd1) begin
      errors++; $display("FAIL sb_count got %0d want 1", err_count); end
    checks++; if (first_err_addr !== 32'h108) begin
      errors++; $display("FAIL sb_first_addr got %h want 00000108", first_err_addr); end
    checks++; if (pass !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL sb_pass got pass=%b berr=%b want 0/0", pass, bus_err); end
    step();
  endtask

  task automatic test_bus_error();
    int cyc; bit ok;
    prep(0, 0, 0, 1, 32'h4);
    do_start(32'h0, 4, 32'h12340000);
    wait_done(1, cyc, ok);
    checks++; if (!ok || cyc != 5) begin
      errors++; $display("FAIL be_done_cycle got %0d (seen=%0d) want 5", cyc, ok); end
    checks++; if (bus_err !== 1'b1 || pass !== 1'b0 || err_count !== '0) begin
      errors++; $display("FAIL be_status got berr=%b pass=%b cnt=%0d want 1/0/0", bus_err, pass, err_count); end
    checks++; if (ns_after_err != 0 || err_seen != 1) begin
      errors++; $display("FAIL be_no_nonseq got %0d NONSEQ after error (err_seen=%0d) want 0/1", ns_after_err, err_seen); end
    checks++; if (mem[0] !== pat_f(32'h12340000, 0) || mem[2] !== 32'hDEAD0002) begin
      errors++; $display("FAIL be_mem got %h/%h want %h/DEAD0002", mem[0], mem[2], pat_f(32'h12340000, 0)); end
    step();
  endtask

  task automatic test_zero_words();
    prep(0, 0, 0, 0, 0);
    checks++; if (HTRANS !== 2'b00) begin
      errors++; $display("FAIL nw_idle0 got trans=%b want 00", HTRANS); end
    do_start(32'h40, 0, 32'h1);
    checks++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || HTRANS !== 2'b00) begin
      errors++; $display("FAIL nw_done got done=%b pass=%b busy=%b trans=%b want 1/1/0/00", done, pass, busy, HTRANS); end
    step();
    checks++; if (done !== 1'b0 || HTRANS !== 2'b00 || bus_err !== 1'b0) begin
      errors++; $display("FAIL nw_after got done=%b trans=%b berr=%b want 0/00/0", done, HTRANS, bus_err); end
  endtask

  task automatic test_start_while_busy();
    int cyc; bit ok;
    prep(0, 0, 0, 0, 0);
    do_start(32'h0, 4, 32'h0F0F0000);
    step();
    checks++; if (busy !== 1'b1) begin
      errors++; $display("FAIL bz_busy got %b want 1", busy); end
    base_addr = 32'h200; num_words = '0; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(3, cyc, ok);
    checks++; if (!ok || cyc != PASSES*8+2) begin
      errors++; $display("FAIL bz_done_cycle got %0d (seen=%0d) want %0d", cyc, ok, PASSES*8+2); end
    checks++; if (pass !== 1'b1 || mem[1] !== pat_f(32'h0F0F0000, 1) || mem[3] !== pat_f(32'h0F0F0000, 3)) begin
      errors++; $display("FAIL bz_result got pass=%b m1=%h m3=%h", pass, mem[1], mem[3]); end
    step();
  endtask

  task automatic test_mid_reset();
    int cyc; bit ok;
    prep(0, 1, 6'd0, 0, 0);
    do_start(32'h0, 4, 32'h20);
    repeat (6) step();
    checks++; if (busy !== 1'b1 || err_count !== 16'd1 || HWRITE !== 1'b0) begin
      errors++; $display("FAIL mr_before got busy=%b cnt=%0d wr=%b want 1/1/0", busy, err_count, HWRITE); end
    HRESETn = 1'b0;
    #1;
    checks++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin
      errors++; $display("FAIL mr_bus got trans=%b addr=%h wr=%b wdata=%h want 0", HTRANS, HADDR, HWRITE, HWDATA); end
    checks++; if (busy !== 0 || done !== 0 || pass !== 0 || err_count !== '0 || first_err_addr !== 32'h0) begin
      errors++; $display("FAIL mr_status got busy=%b done=%b pass=%b cnt=%0d fea=%h want 0", busy, done, pass, err_count, first_err_addr); end
    step();
    HRESETn = 1'b1;
    step();
    prep(0, 0, 0, 0, 0);
    do_start(32'h0, 4, 32'h20);
    wait_done(1, cyc, ok);
    checks++; if (!ok || pass !== 1'b1 || err_count !== '0) begin
      errors++; $display("FAIL mr_rerun got seen=%0d pass=%b cnt=%0d want 1/1/0", ok, pass, err_count); end
    step();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stuck_bit();
    test_bus_error();
    test_zero_words();
    test_start_while_busy();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ram_ahb_bist_master.md
Name: ram_ahb_bist_master

Overview:
- AHB-Lite initiator that self-tests a word-addressed SRAM region through an AHB SRAM slave controller.
- On `start` it writes a deterministic pattern over `num_words` consecutive words, then reads them back and compares.
- It reports pass/fail, a saturating error count, the first failing address and any bus error.
- It sits on the AHB bus as a master (typically behind a bus mux) and is used for power-on/production memory test.

Parameters:
- AW, 13: byte-address width of the tested region; word index width is AW-2.
- ERRW, 16: width of the mismatch counter.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- base_addr  in  32  word-aligned region base; bits[1:0] ignored, treated as 0
- num_words  in  AW-1  number of words to test; 0 = no-op
- seed  in  32  pattern seed
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- pass  out  1  valid from done until next start; 1 = no mismatch and no bus error
- bus_err  out  1  HRESP error seen in the last run
- err_count  out  ERRW  mismatch count, saturating at all-ones
- first_err_addr  out  32  HADDR of the first mismatching read
- HADDR  out  32  AHB address
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only
- HWRITE  out  1  AHB write
- HSIZE  out  3  constant 3'b010
- HBURST  out  3  constant 3'b000
- HWDATA  out  32  write data, driven in the data phase
- HRDATA  in  32  read data
- HREADY  in  1  transfer-complete / bus ready
- HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset values:
  - HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0.
  - busy=0, done=0, pass=0, bus_err=0, err_count=0, first_err_addr=0.
  - FSM in IDLE.
  - Reset takes effect immediately, mid-transfer included; no resume.
- Pattern: `pat(i) = seed ^ {{(34-AW){1'b0}}, i}` for word index i. Address of word i = `base_addr + 4*i`.
- FSM states: IDLE, WR, RD, DRAIN, FIN.
  - IDLE: on start with num_words=0, go to FIN; done is asserted in the next cycle, pass=1, no bus activity.
  - IDLE: on start with num_words>0, clear err_count, first_err_addr and bus_err; go to WR.
  - start is ignored outside IDLE.
- WR:
  - Drive NONSEQ writes for i = 0..N-1, back-to-back.
  - The address phase advances only on a cycle with HREADY=1; HADDR, HTRANS and HWRITE are held while HREADY=0.
  - HWDATA = pat(i) in the cycle after address phase i is accepted, held until HREADY=1.
  - After the address phase of word N-1 is accepted, go to RD.
  - The first read address phase overlaps the last write data phase (pipelined).
- RD:
  - Drive NONSEQ reads for i = 0..N-1 (HWRITE=0) with the same stall rules.
  - The master holds a data-phase pipeline register {valid, i, addr}.
  - On HREADY=1 with valid set, compare HRDATA to pat(i).
  - On mismatch: err_count += 1 (saturating); if this is the first mismatch, latch addr into first_err_addr.
  - After the last read address phase is accepted, drive HTRANS=IDLE and go to DRAIN.
- DRAIN: wait for the last data phase to complete (HREADY=1), then go to FIN.
- FIN: assert done for 1 cycle; pass = (err_count==0) & ~bus_err; busy=0; return to IDLE.
- Error response: when HRESP=1 is sampled with HREADY=0 (first error cycle):
  - drive HTRANS=IDLE in the next cycle and cancel the pending address phase;
  - set bus_err=1;
  - skip the remaining transfers, wait for HREADY=1 and go to FIN.
- Latency with a zero-wait slave: start accepted in cycle 0; address phases in cycles 1..2N; last data phase in cycle 2N+1; done in cycle 2N+2.
- HWDATA is don't-care outside write data phases; it is driven 0.

Optional Feature:
- Macro: RAM_BIST_INV_PASS_EN.
- When defined: after the first RD pass completes, run a second WR then RD pass using `~pat(i)`.
  - Mismatches from both passes accumulate into err_count.
  - Latency becomes 4N+2.
- When undefined: single write/read pass only.

Test Plan:
- base=0x0, N=4, seed=0xA5A50000, zero-wait memory model -> writes 0xA5A50000..0xA5A50003 to 0x0/0x4/0x8/0xC, reads back in order, done at cycle 10, pass=1, err_count=0.
- Same run with the slave inserting 2 wait states per transfer -> HADDR/HTRANS/HWDATA stable during every HREADY=0 cycle, pass=1, done at cycle 26.
- Memory model with bit 5 stuck-at-0 at word 2, seed=0x20 -> err_count=1, first_err_addr=base+0x8, pass=0.
- HRESP=ERROR on write 1 -> HTRANS=IDLE from the second error cycle, no further NONSEQ, bus_err=1, done pulse, pass=0.
- num_words=0 -> HTRANS stays IDLE, done 1 cycle after start, pass=1; a start pulse while busy=1 has no effect.
- HRESETn asserted during RD -> all outputs at reset values immediately; a new start after release completes with pass=1.
